// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and a 256-bit line memory.
// Define DCACHE_STATS_EN to add saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module dcache_ctrl #(
  parameter int INDEX_W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_read_i,
  input  logic         cpu_write_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
`ifdef DCACHE_STATS_EN
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o,
`endif
  output logic [1:0]   fsm_state_o
);
  // Handshake: mem_enable_o with mem_write_o/mem_addr_o/mem_data_o is held stable until a
  // one-cycle mem_ack_i; the CPU holds its request stable for as long as cpu_stall_o is high.
  localparam int LINE_W = 256;
  localparam int LINES  = 1 << INDEX_W;
  localparam int TAG_W  = 32 - 5 - INDEX_W;

  typedef enum logic [1:0] {IDLE, WB_REQ, FILL_REQ, RESUME} state_t;
  state_t state_q, state_d;

  logic [LINES-1:0]  valid_q, dirty_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINE_W-1:0] data_mem [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag, line_tag;
  logic [2:0]         word_sel;
  logic [LINE_W-1:0]  line_rd;
  logic [31:0]        sel_word;
  logic               req, hit;
  logic               store_en, wb_ack, fill_ack;
  logic               unused_addr_bits;

  assign idx              = cpu_addr_i[5 +: INDEX_W];
  assign req_tag          = cpu_addr_i[31 -: TAG_W];
  assign word_sel         = cpu_addr_i[4:2];
  assign unused_addr_bits = ^cpu_addr_i[1:0];
  assign line_rd          = data_mem[idx];
  assign line_tag         = tag_mem[idx];
  assign sel_word         = line_rd[{word_sel, 5'd0} +: 32];
  assign req              = cpu_read_i | cpu_write_i;
  assign hit              = valid_q[idx] && (line_tag == req_tag);
  // Gate with hit so unwritten (never filled) line storage never leaks onto the load bus.
  assign cpu_data_o       = hit ? sel_word : 32'd0;
  assign fsm_state_o      = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    cpu_stall_o  = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'd0;
    mem_data_o   = '0;
    store_en     = 1'b0;
    wb_ack       = 1'b0;
    fill_ack     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && hit) begin
          store_en = cpu_write_i;
        end else if (req && !rst_i) begin
          cpu_stall_o = 1'b1;
          state_d     = (valid_q[idx] && dirty_q[idx]) ? WB_REQ : FILL_REQ;
        end
      end
      WB_REQ: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {line_tag, idx, 5'd0};
        mem_data_o   = line_rd;
        if (mem_ack_i) begin
          wb_ack  = 1'b1;
          state_d = FILL_REQ;
        end
      end
      FILL_REQ: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, idx, 5'd0};
        if (mem_ack_i) begin
          fill_ack = 1'b1;
          state_d  = RESUME;
        end
      end
      RESUME: begin
        // Line is resident now, so the held access completes exactly like a hit.
        store_en = cpu_write_i;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (wb_ack) dirty_q[idx] <= 1'b0;
      if (fill_ack) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (store_en) dirty_q[idx] <= 1'b1;
    end
  end

  // Tags and line data carry no reset; valid bits alone decide whether they mean anything.
  always_ff @(posedge clk_i) begin
    if (fill_ack) begin
      data_mem[idx] <= mem_data_i;
      tag_mem[idx]  <= req_tag;
    end else if (store_en) begin
      data_mem[idx][{word_sel, 5'd0} +: 32] <= cpu_data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic count_hit, count_miss;
  assign count_hit  = (state_q == IDLE) && req && hit;
  assign count_miss = (state_q == IDLE) && req && !hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_o  <= 32'd0;
      miss_cnt_o <= 32'd0;
    end else begin
      if (count_hit && (hit_cnt_o != 32'hFFFF_FFFF))   hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (count_miss && (miss_cnt_o != 32'hFFFF_FFFF)) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed accesses, behavioural line memory, queue-based scoreboard.
module tb_dcache_ctrl;
  logic         clk, rst;
  logic [31:0]  cpu_addr, cpu_data, cpu_rdata;
  logic         cpu_read, cpu_write, cpu_stall;
  logic         mem_en, mem_we, mem_ack, stray_ack, mem_ack_w;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata, mem_rdata;
  logic [1:0]   fsm_state;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  assign mem_ack_w = mem_ack | stray_ack;

  dcache_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_data),
    .cpu_read_i(cpu_read), .cpu_write_i(cpu_write),
    .cpu_data_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .mem_enable_o(mem_en), .mem_write_o(mem_we),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack_w),
`ifdef DCACHE_STATS_EN
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt),
`endif
    .fsm_state_o(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0]  rd_exp_q[$];
  logic [32:0]  req_exp_q[$];
  logic [255:0] wb_exp_q[$];
  logic [255:0] mem_model [logic [31:0]];
  logic [31:0]  ref_mem   [logic [31:0]];
  int mem_lat = 1;
  int wait_cnt;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic logic [255:0] pattern_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = la + 32'h1000_0000 + 32'(w * 4);
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    if (mem_model.exists(la)) return mem_model[la];
    return pattern_line(la);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [255:0] l;
    if (ref_mem.exists(a)) return ref_mem[a];
    l = mem_line({a[31:5], 5'd0});
    return l[a[4:2]*32 +: 32];
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_word(la + 32'(w * 4));
    return l;
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    wait_cnt = 0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_en && !rst) begin
        if (wait_cnt >= mem_lat) begin
          wait_cnt = 0;
          mem_ack = 1'b1;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else        mem_rdata = mem_line(mem_addr);
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_read && !cpu_write && !cpu_stall) begin
        if (rd_exp_q.size() == 0) flag_fail("load_unexpected");
        else check("load_data", cpu_rdata, rd_exp_q.pop_front());
      end
      if (mem_en && mem_ack_w) begin
        if (req_exp_q.size() == 0) flag_fail("mem_req_unexpected");
        else check("mem_req", {mem_we, mem_addr}, req_exp_q.pop_front());
        if (mem_we) begin
          if (wb_exp_q.size() == 0) flag_fail("wb_line_unexpected");
          else check("wb_line", mem_wdata, wb_exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic access(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input bit exp_miss, input int min_stall, input logic [31:0] fill_chk);
    int stalls;
    bit done;
    @(posedge clk); #1;
    cpu_addr = addr;
    cpu_write = wr;
    cpu_read = !wr;
    cpu_data = wdata;
    if (!wr) rd_exp_q.push_back(ref_word(addr));
    stalls = 0;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (cpu_stall) begin
        stalls++;
        if (fill_chk != 32'd0 && fsm_state == 2'd2)
          check("fill_hold", {mem_en, mem_we, mem_addr}, {2'b10, fill_chk});
      end else done = 1;
    end
    if (!done) flag_fail("access_timeout");
    check("stall_seen", 1'(stalls > 0), 1'(exp_miss));
    if (min_stall > 0) check("stall_len", 1'(stalls >= min_stall), 1'b1);
    if (wr) ref_mem[addr] = wdata;
    @(posedge clk); #1;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic exp_fill(input logic [31:0] la);
    req_exp_q.push_back({1'b0, la});
  endtask

  task automatic exp_wb(input logic [31:0] la);
    req_exp_q.push_back({1'b1, la});
    wb_exp_q.push_back(ref_line(la));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] l40;
    bit seen;
    rst = 1'b1;
    cpu_addr = '0; cpu_data = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    stray_ack = 1'b0;
    l40 = pattern_line(32'h40);
    l40[31:0] = 32'hDEAD_BEEF;
    mem_model[32'h40] = l40;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_data", mem_wdata, 256'd0);
    check("rst_state", fsm_state, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // clean miss, then hits and a store into the same line
    exp_fill(32'h40);
    access(32'h40, 1'b0, 32'd0, 1, 1, 32'h40);
    access(32'h44, 1'b1, 32'h1234_5678, 0, 0, 32'd0);
    access(32'h44, 1'b0, 32'd0, 0, 0, 32'd0);
    access(32'h40, 1'b0, 32'd0, 0, 0, 32'd0);

    // dirty miss on index 2: write back 0x40, fill 0x440; then bring 0x40 back
    exp_wb(32'h40);
    exp_fill(32'h440);
    access(32'h440, 1'b0, 32'd0, 1, 2, 32'h440);
    exp_fill(32'h40);
    access(32'h44, 1'b0, 32'd0, 1, 1, 32'h40);

    // slow fill: request held stable for the whole wait
    mem_lat = 10;
    exp_fill(32'h80);
    access(32'h80, 1'b0, 32'd0, 1, 10, 32'h80);
    mem_lat = 1;

    // stray ack in IDLE is ignored
    @(posedge clk); #1; stray_ack = 1'b1;
    @(posedge clk); #1; stray_ack = 1'b0;
    @(negedge clk);
    check("stray_state", fsm_state, 2'd0);
    check("stray_mem_en", mem_en, 1'b0);
    check("stray_stall", cpu_stall, 1'b0);
    access(32'h80, 1'b0, 32'd0, 0, 0, 32'd0);

    // write miss allocates then merges; neighbours keep fill data
    exp_fill(32'hC0);
    access(32'hC8, 1'b1, 32'hCAFE_F00D, 1, 1, 32'hC0);
    access(32'hC8, 1'b0, 32'd0, 0, 0, 32'd0);
    access(32'hCC, 1'b0, 32'd0, 0, 0, 32'd0);

    // reset in the middle of a writeback
    access(32'h84, 1'b1, 32'h5555_AAAA, 0, 0, 32'd0);
    mem_lat = 20;
    @(posedge clk); #1;
    cpu_addr = 32'h484;
    cpu_read = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (fsm_state == 2'd1) seen = 1;
    end
    check("wb_reached", seen, 1'b1);
    check("wb_req", {mem_en, mem_we, mem_addr}, {2'b11, 32'h80});
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_mem_en", mem_en, 1'b0);
    check("arst_mem_we", mem_we, 1'b0);
    check("arst_stall", cpu_stall, 1'b0);
    check("arst_mem_addr", mem_addr, 32'd0);
    check("arst_mem_data", mem_wdata, 256'd0);
    check("arst_state", fsm_state, 2'd0);
    cpu_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_mem.delete();
    mem_lat = 1;

    // valid bits were cleared and the abandoned writeback never reached memory
    exp_fill(32'h80);
    access(32'h84, 1'b0, 32'd0, 1, 1, 32'h80);
    access(32'h84, 1'b0, 32'd0, 0, 0, 32'd0);
    access(32'h80, 1'b0, 32'd0, 0, 0, 32'd0);
    access(32'h9C, 1'b0, 32'd0, 0, 0, 32'd0);
    exp_fill(32'h100);
    access(32'h100, 1'b0, 32'd0, 1, 1, 32'h100);
`ifdef DCACHE_STATS_EN
    @(negedge clk);
    check("hit_cnt", hit_cnt, 32'd3);
    check("miss_cnt", miss_cnt, 32'd2);
`endif

    repeat (3) @(posedge clk);
    check("rd_q_drained", 32'(rd_exp_q.size()), 32'd0);
    check("req_q_drained", 32'(req_exp_q.size()), 32'd0);
    check("wb_q_drained", 32'(wb_exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
